// File: rtl/dec_per_bin_pkg.sv
// Shared profile codes, FSM states and permission masks for the profile decoder.
// Both the profile-switch encoder and dec_per_bin import this package.
package dec_per_bin_pkg;

    localparam logic [1:0] PER_ADM    = 2'b11;
    localparam logic [1:0] PER_TESTER = 2'b10;
    localparam logic [1:0] PER_USER   = 2'b01;
    localparam logic [1:0] PER_GUEST  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CONFIRM = 2'b01,
        ST_ACTIVE  = 2'b10,
        ST_BAD     = 2'b11
    } state_t;

    typedef struct packed {
        logic cfg;
        logic wr;
        logic rd;
    } perm_t;

    localparam perm_t PERM_GUEST  = 3'b000;
    localparam perm_t PERM_USER   = 3'b001;
    localparam perm_t PERM_TESTER = 3'b011;
    localparam perm_t PERM_ADM    = 3'b111;

    function automatic logic [3:0] prof_onehot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    function automatic perm_t perm_decode(input logic [1:0] code);
        perm_t p;
        case (code)
            PER_ADM:    p = PERM_ADM;
            PER_TESTER: p = PERM_TESTER;
            PER_USER:   p = PERM_USER;
            default:    p = PERM_GUEST;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/dec_per_bin_timer.sv
// Loadable saturating up-counter; holds at i_tc_val and flags it on o_tc.
// Clear has priority over load, load over count.
module dec_per_bin_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic [CNT_W-1:0] i_ld_val,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_tc_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_en && (r_cnt != i_tc_val)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/dec_per_bin.sv
// Profile-code receiver: confirms a stable code, holds it as the session profile, decodes permissions.
// Outputs are registered from the current state, so they trail the state register by one cycle.
module dec_per_bin
    import dec_per_bin_pkg::*;
#(
    parameter int CONFIRM_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_per_code,
    input  logic       i_login_req,
    input  logic       i_logout,
    input  logic       i_activity,
    output logic [3:0] o_prof_oh,
    output logic       o_perm_rd,
    output logic       o_perm_wr,
    output logic       o_perm_cfg,
    output logic       o_busy,
    output logic       o_login_err,
    output logic       o_timeout
);

    localparam logic [CNT_W-1:0] C_CCNT_TC = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TCNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_pend;
    logic       w_match;

    logic       w_ccnt_clr, w_ccnt_en, w_ccnt_tc;
    logic       w_tcnt_clr, w_tcnt_en, w_tcnt_tc;

    logic [3:0] w_prof_oh_nxt;
    perm_t      w_perm_nxt;
    logic       w_busy_nxt, w_err_nxt, w_to_nxt;

    logic [3:0] r_prof_oh;
    perm_t      r_perm;
    logic       r_busy, r_err, r_to;

    assign w_match = (i_per_code == r_pend);

    dec_per_bin_timer #(.CNT_W(CNT_W)) u_ccnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_ccnt_clr),
        .i_ld     (1'b0),
        .i_ld_val ('0),
        .i_en     (w_ccnt_en),
        .i_tc_val (C_CCNT_TC),
        .o_tc     (w_ccnt_tc)
    );

    dec_per_bin_timer #(.CNT_W(CNT_W)) u_tcnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_tcnt_clr),
        .i_ld     (1'b0),
        .i_ld_val ('0),
        .i_en     (w_tcnt_en),
        .i_tc_val (C_TCNT_TC),
        .o_tc     (w_tcnt_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_pend  <= PER_GUEST;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && i_login_req) begin
                r_pend <= i_per_code;
            end
        end
    end

    // Logout outranks every other event; activity outranks the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_ccnt_clr  = 1'b0;
        w_ccnt_en   = 1'b0;
        w_tcnt_clr  = 1'b0;
        w_tcnt_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_login_req) begin
                    w_state_nxt = ST_CONFIRM;
                    w_ccnt_clr  = 1'b1;
                end
            end
            ST_CONFIRM: begin
                w_ccnt_en = w_match;
                if (i_logout || !w_match) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ccnt_tc) begin
                    w_state_nxt = ST_ACTIVE;
                    w_tcnt_clr  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                w_tcnt_en = 1'b1;
                if (i_logout) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_activity) begin
                    w_tcnt_clr = 1'b1;
                end else if (w_tcnt_tc) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_prof_oh_nxt = prof_onehot(PER_GUEST);
        w_perm_nxt    = PERM_GUEST;
        w_busy_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_to_nxt      = 1'b0;
        case (r_state)
            ST_CONFIRM: begin
                w_busy_nxt = 1'b1;
                w_err_nxt  = !i_logout && !w_match;
            end
            ST_ACTIVE: begin
                w_prof_oh_nxt = prof_onehot(r_pend);
                w_perm_nxt    = perm_decode(r_pend);
                w_to_nxt      = !i_logout && !i_activity && w_tcnt_tc;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prof_oh <= prof_onehot(PER_GUEST);
            r_perm    <= PERM_GUEST;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            r_prof_oh <= w_prof_oh_nxt;
            r_perm    <= w_perm_nxt;
            r_busy    <= w_busy_nxt;
            r_err     <= w_err_nxt;
            r_to      <= w_to_nxt;
        end
    end

    assign o_prof_oh   = r_prof_oh;
    assign o_perm_rd   = r_perm.rd;
    assign o_perm_wr   = r_perm.wr;
    assign o_perm_cfg  = r_perm.cfg;
    assign o_busy      = r_busy;
    assign o_login_err = r_err;
    assign o_timeout   = r_to;

endmodule

// File: tb/tb_dec_per_bin.sv
// Scoreboard bench for dec_per_bin: each output change is matched against a queued (cycle, value) pair.
module tb_dec_per_bin;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] per_code = 2'b00;
    logic       login_req = 1'b0;
    logic       logout = 1'b0;
    logic       activity = 1'b0;

    logic [3:0] prof_oh;
    logic       perm_rd, perm_wr, perm_cfg, busy, login_err, timeout;

    dec_per_bin #(
        .CONFIRM_CYCLES (4),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_per_code  (per_code),
        .i_login_req (login_req),
        .i_logout    (logout),
        .i_activity  (activity),
        .o_prof_oh   (prof_oh),
        .o_perm_rd   (perm_rd),
        .o_perm_wr   (perm_wr),
        .o_perm_cfg  (perm_cfg),
        .o_busy      (busy),
        .o_login_err (login_err),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0] oh;
        logic       rd;
        logic       wr;
        logic       cfg;
        logic       busy;
        logic       err;
        logic       to;
    } out_t;

    typedef struct packed {
        int   cyc;
        out_t v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic out_t mk(input logic [3:0] oh, input logic [2:0] rwc,
                                input logic b, input logic e, input logic t);
        out_t o;
        o.oh   = oh;
        o.rd   = rwc[2];
        o.wr   = rwc[1];
        o.cfg  = rwc[0];
        o.busy = b;
        o.err  = e;
        o.to   = t;
        return o;
    endfunction

    out_t V_G, V_BZ, V_BZE, V_GTO, V_ADM, V_TST, V_USR, V_USRTO;

    task automatic exp_ev(input int c, input out_t v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Monitor: every change of the output bundle is an output event.
    out_t cur, prev;
    bit   seen = 1'b0;
    exp_t got_e;
    always @(negedge clk) begin
        cur = {prof_oh, perm_rd, perm_wr, perm_cfg, busy, login_err, timeout};
        if (!seen || (cur !== prev)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got=%b required=no change", cyc, cur);
            end else begin
                got_e = sb.pop_front();
                if ((got_e.cyc != cyc) || (cur !== got_e.v)) begin
                    n_bad++;
                    $display("FAIL event cyc=%0d got=%b required cyc=%0d val=%b",
                             cyc, cur, got_e.cyc, got_e.v);
                end
            end
        end
        seen = 1'b1;
        prev = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic login(input logic [1:0] code, output int k);
        per_code  = code;
        login_req = 1'b1;
        tick();
        k = cyc;
        login_req = 1'b0;
    endtask

    task automatic pulse_logout(output int l);
        logout = 1'b1;
        tick();
        l = cyc;
        logout = 1'b0;
    endtask

    int k, l;

    initial begin
        V_G     = mk(4'b0001, 3'b000, 1'b0, 1'b0, 1'b0);
        V_BZ    = mk(4'b0001, 3'b000, 1'b1, 1'b0, 1'b0);
        V_BZE   = mk(4'b0001, 3'b000, 1'b1, 1'b1, 1'b0);
        V_GTO   = mk(4'b0001, 3'b000, 1'b0, 1'b0, 1'b1);
        V_ADM   = mk(4'b1000, 3'b111, 1'b0, 1'b0, 1'b0);
        V_TST   = mk(4'b0100, 3'b110, 1'b0, 1'b0, 1'b0);
        V_USR   = mk(4'b0010, 3'b100, 1'b0, 1'b0, 1'b0);
        V_USRTO = mk(4'b0010, 3'b100, 1'b0, 1'b0, 1'b1);

        // reset held for two edges
        exp_ev(1, V_G);
        repeat (2) tick();
        rst = 1'b0;

        // ADM login, then logout
        login(2'b11, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 5, V_ADM);
        wait_to(k + 6);
        pulse_logout(l);
        exp_ev(l + 1, V_G);
        repeat (2) tick();

        // code changes on the second confirm cycle
        login(2'b10, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 2, V_BZE);
        exp_ev(k + 3, V_G);
        wait_to(k + 1);
        per_code = 2'b01;
        wait_to(k + 4);

        // logout during confirm beats a simultaneous mismatch: no error pulse
        login(2'b11, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 3, V_G);
        wait_to(k + 1);
        logout   = 1'b1;
        per_code = 2'b00;
        tick();
        logout = 1'b0;
        wait_to(k + 5);

        // USER session times out after 8 idle ACTIVE cycles
        login(2'b01, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 5, V_USR);
        exp_ev(k + 12, V_USRTO);
        exp_ev(k + 13, V_G);
        wait_to(k + 15);

        // activity every 5 cycles keeps the session alive for 100 cycles
        login(2'b01, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 5, V_USR);
        wait_to(k + 4);
        for (int i = 0; i < 20; i++) begin
            activity = 1'b1;
            tick();
            activity = 1'b0;
            repeat (4) tick();
        end
        pulse_logout(l);
        exp_ev(l + 1, V_G);
        repeat (2) tick();

        // logout and activity together
        login(2'b10, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 5, V_TST);
        wait_to(k + 6);
        logout   = 1'b1;
        activity = 1'b1;
        tick();
        l = cyc;
        logout   = 1'b0;
        activity = 1'b0;
        exp_ev(l + 1, V_G);
        repeat (3) tick();

        // logout on the terminal-count cycle: no timeout pulse
        login(2'b01, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 5, V_USR);
        exp_ev(k + 13, V_G);
        wait_to(k + 11);
        logout = 1'b1;
        tick();
        logout = 1'b0;
        wait_to(k + 15);

        // login_req ignored in ACTIVE; logout then a fresh login switches profile
        login(2'b10, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 5, V_TST);
        wait_to(k + 5);
        per_code  = 2'b11;
        login_req = 1'b1;
        tick();
        login_req = 1'b0;
        wait_to(k + 8);
        pulse_logout(l);
        exp_ev(l + 1, V_G);
        tick();
        login(2'b11, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 5, V_ADM);
        wait_to(k + 6);
        pulse_logout(l);
        exp_ev(l + 1, V_G);
        repeat (2) tick();

        // reset mid-confirm, with a mismatch in the same cycle
        login(2'b11, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 3, V_G);
        wait_to(k + 2);
        rst      = 1'b1;
        per_code = 2'b00;
        tick();
        rst      = 1'b0;
        per_code = 2'b11;
        wait_to(k + 12);

        // reset mid-session
        login(2'b11, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 5, V_ADM);
        wait_to(k + 6);
        exp_ev(k + 7, V_G);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_to(k + 20);

        // GUEST login runs the full confirm and still times out
        login(2'b00, k);
        exp_ev(k + 1, V_BZ);
        exp_ev(k + 5, V_G);
        exp_ev(k + 12, V_GTO);
        exp_ev(k + 13, V_G);
        wait_to(k + 16);

        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events left=%0d required=0 next_cyc=%0d",
                     sb.size(), sb[0].cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
